// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler: state encoding,
// default widths/timeouts and the round-robin winner search.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } sched_state_t;

    localparam int DEF_D_WIDTH  = 14;
    localparam int DEF_BUSY_TMO = 4;
    localparam int MAX_REQ      = 8;

    // Returns {found, index}: first set request at or after ptr, ascending with wrap over n ports.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int unsigned        n);
        logic [3:0]  pick;
        int unsigned idx;
        pick = 4'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if ((k < n) && !pick[3] && req[idx[2:0]]) pick = {1'b1, idx[2:0]};
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search over N_REQ requesters (N_REQ <= 8),
// starting at i_ptr; o_valid is high when any request is present.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [PW-1:0]    o_winner,
    output logic             o_valid
);

    logic [3:0] w_pick;

    always_comb begin
        w_pick = rr_pick(MAX_REQ'(i_req), 3'(i_ptr), N_REQ);
    end

    assign o_valid  = w_pick[3];
    assign o_winner = PW'(w_pick[2:0]);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// Define UART_SCHED_PRIO_EN to make requester 0 strictly highest priority.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int BUSY_TMO = DEF_BUSY_TMO,
    parameter int PW       = $clog2(N_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*D_WIDTH-1:0]   i_req_data,
    output logic [N_REQ-1:0]           o_ack,
    output logic                       o_tx_ena,
    output logic [D_WIDTH-1:0]         o_tx_data,
    input  logic                       i_tx_busy,
    output logic [PW-1:0]              o_grant_id,
    output logic                       o_idle,
    output logic                       o_err
);

    localparam int CW = $clog2(BUSY_TMO + 1);

    sched_state_t r_state, w_next;

    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] r_ack;
    logic             r_tx_ena;
    logic [D_WIDTH-1:0] r_tx_data;
    logic [PW-1:0]    r_grant_id;
    logic             r_idle;
    logic             r_err;

    logic [N_REQ-1:0] w_arb_req;
    logic [PW-1:0]    w_rr_winner;
    logic             w_rr_valid;
    logic [PW-1:0]    w_winner;
    logic             w_ptr_upd;
    logic             w_grant;
    logic             w_timeout;

`ifdef UART_SCHED_PRIO_EN
    // Requester 0 bypasses the rotation; the others rotate among themselves.
    assign w_arb_req = i_req & ~N_REQ'(1);
    assign w_winner  = i_req[0] ? '0 : w_rr_winner;
    assign w_ptr_upd = !i_req[0];
    assign w_grant   = (r_state == S_IDLE) && !i_tx_busy && (i_req[0] || w_rr_valid);
`else
    assign w_arb_req = i_req;
    assign w_winner  = w_rr_winner;
    assign w_ptr_upd = 1'b1;
    assign w_grant   = (r_state == S_IDLE) && !i_tx_busy && w_rr_valid;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .i_req    (w_arb_req),
        .i_ptr    (r_ptr),
        .o_winner (w_rr_winner),
        .o_valid  (w_rr_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:      if (w_grant) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_cnt == CW'(BUSY_TMO - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WAIT_DONE: if (!i_tx_busy) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Strobes are set on the grant edge so they line up exactly with the ISSUE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_tx_ena   <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_idle     <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_ack    <= '0;
            r_tx_ena <= 1'b0;
            if (w_grant) begin
                r_ack      <= N_REQ'(1) << w_winner;
                r_tx_ena   <= 1'b1;
                r_tx_data  <= i_req_data[w_winner*D_WIDTH +: D_WIDTH];
                r_grant_id <= w_winner;
                if (w_ptr_upd)
                    r_ptr <= (w_winner == PW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
            end
            if ((r_state == S_WAIT_BUSY) && !i_tx_busy && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            r_idle <= (w_next == S_IDLE);
            r_err  <= r_err | w_timeout;
        end
    end

    assign o_ack      = r_ack;
    assign o_tx_ena   = r_tx_ena;
    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant_id;
    assign o_idle     = r_idle;
    assign o_err      = r_err;

endmodule
